// File: rtl/vga_line_pkg.sv
// Shared constants and types for the VGA pixel-fetch path.
// Tiled frame-buffer geometry, pixel/word types, fill FSM states.
package vga_line_pkg;

  localparam int WIDTH_PX          = 640;
  localparam int HEIGHT_LNS        = 480;
  localparam int H_B_PORCH_MAX_PX  = 144;
  localparam int V_B_PORCH_MAX_LNS = 35;
  localparam int TILE_WIDTH        = 4;
  localparam int PXL_WIDTH         = 12;
  localparam int TILE_PER_ROW      = 4;
  localparam int PXL_CTR_WIDTH     = 10;
  localparam int LN_CTR_WIDTH      = 10;

  localparam int TILE_PER_LINE    = WIDTH_PX / TILE_WIDTH;
  localparam int TILE_LINES       = HEIGHT_LNS / TILE_WIDTH;
  localparam int FBUFF_DATA_WIDTH = TILE_PER_ROW * PXL_WIDTH;
  localparam int FBUFF_DEPTH      =
    TILE_PER_LINE * TILE_LINES / TILE_PER_ROW;
  localparam int FBUFF_ADDR_WIDTH = $clog2(FBUFF_DEPTH);
  localparam int ROWS_PER_LINE    = TILE_PER_LINE / TILE_PER_ROW;

  localparam int TILE_SHIFT    = $clog2(TILE_WIDTH);
  localparam int ROW_SHIFT     = $clog2(TILE_PER_ROW);
  localparam int TILE_ID_WIDTH = $clog2(TILE_PER_LINE);
  localparam int TLINE_WIDTH   = $clog2(TILE_LINES);
  localparam int ROW_IDX_WIDTH = $clog2(ROWS_PER_LINE);

  typedef logic [PXL_WIDTH-1:0]        pixel_t;
  typedef logic [FBUFF_DATA_WIDTH-1:0] fbuff_word_t;
  typedef logic [FBUFF_ADDR_WIDTH-1:0] fbuff_addr_t;

  typedef enum logic [1:0] {
    FILL_IDLE,
    FILL_REQ,
    FILL_WAIT,
    FILL_DONE
  } fill_state_e;

  // Row address of word idx within tile line
  function automatic fbuff_addr_t row_addr(
    input logic [TLINE_WIDTH-1:0]   line,
    input logic [ROW_IDX_WIDTH-1:0] idx
  );
    return fbuff_addr_t'(line) * fbuff_addr_t'(ROWS_PER_LINE)
         + fbuff_addr_t'(idx);
  endfunction

endpackage

// File: rtl/fbuff_ram.sv
// Tiled frame-buffer storage: single-port synchronous RAM.
// External writes win; a colliding read is simply not granted.
module fbuff_ram
  import vga_line_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [FBUFF_ADDR_WIDTH-1:0] wr_addr,
  input  logic [FBUFF_DATA_WIDTH-1:0] wr_data,
  input  logic                        rd_req,
  input  logic [FBUFF_ADDR_WIDTH-1:0] rd_addr,
  output logic                        rd_gnt,
  output logic                        rd_rsp,
  output logic [FBUFF_DATA_WIDTH-1:0] rd_data
);

  fbuff_word_t mem [FBUFF_DEPTH];

  assign rd_gnt = rd_req & ~wr_en;

  // Single port: write has priority, read data registered
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end else if (rd_req) begin
      rd_data <= mem[rd_addr];
    end
  end

  // Response strobe one cycle after a granted read
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_rsp <= 1'b0;
    end else begin
      rd_rsp <= rd_gnt;
    end
  end

endmodule

// File: rtl/vga_line_pipeline.sv
// Pixel-fetch path: frame buffer, ping-pong line buffers,
// fill controller and zero-latency output mux.
module vga_line_pipeline
  import vga_line_pkg::*;
(
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [PXL_CTR_WIDTH-1:0]    pxl_cntr_i,
  input  logic [LN_CTR_WIDTH-1:0]     ln_cntr_i,
  input  logic                        fbuff_wr_en_i,
  input  logic [FBUFF_ADDR_WIDTH-1:0] fbuff_wr_addr_i,
  input  logic [FBUFF_DATA_WIDTH-1:0] fbuff_wr_data_i,
  output logic [PXL_WIDTH-1:0]        disp_pxl_o
);

  logic                     in_h;
  logic                     in_v;
  logic [LN_CTR_WIDTH-1:0]  d;
  logic [PXL_CTR_WIDTH-1:0] hx;
  logic [TLINE_WIDTH-1:0]   cur_line;
  logic [TILE_ID_WIDTH-1:0] cur_tile;

  logic                     frame_start;
  logic                     line_start;
  logic                     trig;
  logic [TLINE_WIDTH-1:0]   trig_line;

  fill_state_e              state;
  logic [ROW_IDX_WIDTH-1:0] row;
  logic [TLINE_WIDTH-1:0]   fill_line;
  logic                     fill_buf;
  logic [1:0]               buff_fill_done;
  logic [1:0]               buff_ready;
  logic [1:0]               ready_clr;
  logic                     last_row;

  logic                     rd_req;
  logic                     rd_gnt;
  logic                     rd_rsp;
  fbuff_addr_t              rd_addr;
  fbuff_word_t              rd_data;
  logic                     lb_we;

  pixel_t lbuf [2][TILE_PER_LINE];

  assign in_v =
    (ln_cntr_i >= LN_CTR_WIDTH'(V_B_PORCH_MAX_LNS)) &&
    (ln_cntr_i <  LN_CTR_WIDTH'(V_B_PORCH_MAX_LNS + HEIGHT_LNS));
  assign in_h =
    (pxl_cntr_i >= PXL_CTR_WIDTH'(H_B_PORCH_MAX_PX)) &&
    (pxl_cntr_i <  PXL_CTR_WIDTH'(H_B_PORCH_MAX_PX + WIDTH_PX));

  assign d        = ln_cntr_i - LN_CTR_WIDTH'(V_B_PORCH_MAX_LNS);
  assign hx       = pxl_cntr_i - PXL_CTR_WIDTH'(H_B_PORCH_MAX_PX);
  assign cur_line = TLINE_WIDTH'(d >> TILE_SHIFT);
  assign cur_tile = TILE_ID_WIDTH'(hx >> TILE_SHIFT);

  assign frame_start = (ln_cntr_i == '0) && (pxl_cntr_i == '0);
  assign line_start  =
    in_v && (pxl_cntr_i == '0) &&
    (d[TILE_SHIFT-1:0] == '0) &&
    (cur_line < TLINE_WIDTH'(TILE_LINES - 1));
  assign trig      = frame_start | line_start;
  assign trig_line =
    frame_start ? '0 : cur_line + TLINE_WIDTH'(1);

  assign rd_req   = (state == FILL_REQ);
  assign rd_addr  = row_addr(fill_line, row);
  assign lb_we    = (state == FILL_WAIT) && rd_rsp;
  assign last_row = (row == ROW_IDX_WIDTH'(ROWS_PER_LINE - 1));

  assign ready_clr =
    ((state == FILL_IDLE) && trig) ?
    (2'b01 << trig_line[0]) : 2'b00;

  fbuff_ram u_ram (
    .clk     (clk_i),
    .rst     (rst_i),
    .wr_en   (fbuff_wr_en_i),
    .wr_addr (fbuff_wr_addr_i),
    .wr_data (fbuff_wr_data_i),
    .rd_req  (rd_req),
    .rd_addr (rd_addr),
    .rd_gnt  (rd_gnt),
    .rd_rsp  (rd_rsp),
    .rd_data (rd_data)
  );

  // Fill FSM: walk the 40 rows of one tile line
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= FILL_IDLE;
      row            <= '0;
      fill_line      <= '0;
      fill_buf       <= 1'b0;
      buff_fill_done <= '0;
    end else begin
      buff_fill_done <= '0;
      case (state)
        FILL_IDLE: begin
          if (trig) begin
            fill_line <= trig_line;
            fill_buf  <= trig_line[0];
            row       <= '0;
            state     <= FILL_REQ;
          end
        end
        FILL_REQ: begin
          if (rd_gnt) begin
            state <= FILL_WAIT;
          end
        end
        FILL_WAIT: begin
          if (!rd_rsp) begin
            state <= FILL_REQ;
          end else if (last_row) begin
            state <= FILL_DONE;
          end else begin
            row   <= row + ROW_IDX_WIDTH'(1);
            state <= FILL_REQ;
          end
        end
        FILL_DONE: begin
          buff_fill_done[fill_buf] <= 1'b1;
          state                    <= FILL_IDLE;
        end
        default: state <= FILL_IDLE;
      endcase
    end
  end

  // A buffer is shown only once a fill into it has finished
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      buff_ready <= '0;
    end else begin
      buff_ready <= (buff_ready | buff_fill_done) & ~ready_clr;
    end
  end

  // Line buffers: four tiles land per read response
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int b = 0; b < 2; b++) begin
        for (int t = 0; t < TILE_PER_LINE; t++) begin
          lbuf[b][t] <= '0;
        end
      end
    end else if (lb_we) begin
      for (int k = 0; k < TILE_PER_ROW; k++) begin
        lbuf[fill_buf][{row, ROW_SHIFT'(k)}] <=
          rd_data[k*PXL_WIDTH +: PXL_WIDTH];
      end
    end
  end

  // Output mux straight from counters, blanked outside window
  always_comb begin
    disp_pxl_o = '0;
    if (in_v && in_h && !rst_i && buff_ready[cur_line[0]]) begin
      disp_pxl_o = lbuf[cur_line[0]][cur_tile];
    end
  end

endmodule

// File: tb/tb_vga_line_pipeline.sv
// Directed bench for vga_line_pipeline: tile-pattern frames,
// blanking, fill timing, mid-frame reset, live frame-buffer write.
module tb_vga_line_pipeline;
  import vga_line_pkg::*;

  localparam int K = 16;

  typedef struct {
    int     ln;
    int     px;
    pixel_t v;
  } spot_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  px;
  logic [9:0]  ln;
  logic        wr_en;
  logic [12:0] wr_addr;
  logic [47:0] wr_data;
  logic [11:0] disp;

  int n_cmp = 0;
  int n_bad = 0;
  int wr_ln = -1;
  int lat = -1;
  int cnt = -1;
  int bad_wr = 0;
  bit armed = 1'b0;

  pixel_t ref_fb [TILE_LINES][TILE_PER_LINE];
  spot_t  spots[$];

  vga_line_pipeline dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .pxl_cntr_i      (px),
    .ln_cntr_i       (ln),
    .fbuff_wr_en_i   (wr_en),
    .fbuff_wr_addr_i (wr_addr),
    .fbuff_wr_data_i (wr_data),
    .disp_pxl_o      (disp)
  );

  always #20 clk = ~clk;

  initial begin
    #(200000 * 40);
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s ln=%0d px=%0d got=%h want=%h",
               tag, ln, px, obs, exp);
    end
  endtask

  function automatic pixel_t ref_pix(input int l, input int t);
    logic [3:0] c;
    c = (l % 2 == 0) ? 4'(t) : 4'(15 - t);
    return {c, c, c};
  endfunction

  function automatic fbuff_word_t row_word(input int r);
    fbuff_word_t w;
    int l;
    int i;
    l = r / ROWS_PER_LINE;
    i = r % ROWS_PER_LINE;
    for (int k = 0; k < 4; k++) begin
      w[k*12 +: 12] = ref_fb[l][4*i+k];
    end
    return w;
  endfunction

  task automatic at(input int p, input string tag, input int exp);
    px = 10'(p);
    @(negedge clk);
    chk(tag, int'(disp), exp);
    @(posedge clk);
    #1;
  endtask

  task automatic run_line(input int l, input int stride);
    int dd;
    int tl;
    int s;
    ln = 10'(l);
    for (int p = 0; p < K; p++) begin
      wr_en = 1'b0;
      if (l == wr_ln && p >= 2 && p <= 6) begin
        wr_en = 1'b1;
        if (p == 2) begin
          wr_addr = 13'd0;
          wr_data = {12'h333, 12'h222, 12'h111, 12'hABC};
          ref_fb[0][0] = 12'hABC;
        end else begin
          wr_addr = 13'(240 + p - 3);
          wr_data = row_word(240 + p - 3);
        end
      end
      at(p, "hblank", 0);
    end
    wr_en = 1'b0;
    if (l >= 35 && l < 515) begin
      dd = l - 35;
      tl = dd / 4;
      s  = (tl == 6) ? 1 : stride;
      if (s > 0 && dd % 4 == tl % 4) begin
        at(143, "hedge_lo", 0);
        for (int t = tl % s; t < 160; t += s) begin
          at(144 + 4*t + (t + tl) % 4, "pix", int'(ref_fb[tl][t]));
        end
        at(783, "hedge_hi", int'(ref_fb[tl][159]));
        at(784, "hedge_out", 0);
        at(799, "hend", 0);
      end
      foreach (spots[i]) begin
        if (spots[i].ln == l) begin
          at(spots[i].px, "spot", int'(spots[i].v));
        end
      end
    end else begin
      at(300, "vblank", 0);
    end
  endtask

  task automatic run_frame(input int stride, input int last_ln);
    for (int l = 0; l <= last_ln; l++) begin
      run_line(l, stride);
    end
  endtask

  // Fill-latency and forbidden-write observers
  always @(negedge clk) begin
    if (cnt >= 0 && lat < 0) begin
      cnt++;
      if (dut.buff_fill_done[1]) lat = cnt;
      if (cnt > 2000) lat = 9999;
    end
    if (!armed && ln == 10'd35 && px == 10'd0) begin
      armed = 1'b1;
      cnt   = 0;
    end
    if (ln >= 10'd35 && ln < 10'd39 && dut.lb_we && !dut.fill_buf)
      bad_wr++;
  end

  initial begin
    rst     = 1'b1;
    ln      = 10'd520;
    px      = 10'd1;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    for (int l = 0; l < TILE_LINES; l++) begin
      for (int t = 0; t < TILE_PER_LINE; t++) begin
        ref_fb[l][t] = ref_pix(l, t);
      end
    end
    @(posedge clk);
    #1;
    at(1, "rst_hold", 0);
    rst = 1'b0;
    ln  = 10'd35;
    at(144, "rst_lbuf", 0);
    ln  = 10'd520;
    px  = 10'd1;

    for (int r = 0; r < FBUFF_DEPTH; r++) begin
      wr_en   = 1'b1;
      wr_addr = 13'(r);
      wr_data = row_word(r);
      @(posedge clk);
      #1;
    end
    wr_en = 1'b0;

    spots.push_back('{35, 144, 12'h000});
    spots.push_back('{35, 148, 12'h111});
    spots.push_back('{35, 783, 12'hFFF});
    spots.push_back('{39, 144, 12'hFFF});
    spots.push_back('{514, 783, 12'h000});
    run_frame(1, 524);
    chk("fill_lat", int'(lat > 0 && lat <= 121), 1);
    spots.delete();

    run_frame(1, 524);

    run_frame(0, 34);
    ln = 10'd35;
    for (int p = 0; p < 20; p++) at(p, "hblank", 0);
    rst = 1'b1;
    px  = 10'd20;
    #5;
    chk("rst_out", int'(disp), 0);
    px = 10'd148;
    @(negedge clk);
    chk("rst_out_vis", int'(disp), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    at(148, "rst_clear", 0);

    wr_ln = 55;
    run_frame(20, 524);
    wr_ln = -1;

    spots.push_back('{35, 144, 12'hABC});
    spots.push_back('{35, 148, 12'h111});
    run_frame(1, 39);

    chk("buf0_wr", bad_wr, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_line_pipeline.md
Name: vga_line_pipeline

Overview:
- Pixel-fetch path of the VGA controller: tiled frame-buffer RAM, two ping-pong line buffers, and a line-buffer controller.
- Driven by the timing generator's pixel and line counters.
- Emits the colour pixel for the current counter position, with zero-cycle latency.
- An external write port loads the frame buffer (processing system or testbench).

Parameters:
- WIDTH_PX, 640, visible pixels per line
- HEIGHT_LNS, 480, visible lines
- H_B_PORCH_MAX_PX, 144, first visible pixel count (sync+back porch)
- V_B_PORCH_MAX_LNS, 35, first visible line count
- TILE_WIDTH, 4, tile edge in pixels (TILE_WIDTH x TILE_WIDTH)
- PXL_WIDTH, 12, RGB444 pixel width
- TILE_PER_ROW, 4, tiles per frame-buffer word
- PXL_CTR_WIDTH, 10, pixel counter width
- LN_CTR_WIDTH, 10, line counter width
- Derived: TILE_PER_LINE=WIDTH_PX/TILE_WIDTH (160); TILE_LINES=HEIGHT_LNS/TILE_WIDTH (120); FBUFF_DATA_WIDTH=TILE_PER_ROW*PXL_WIDTH (48); FBUFF_DEPTH=TILE_PER_LINE*TILE_LINES/TILE_PER_ROW (4800); FBUFF_ADDR_WIDTH=$clog2(FBUFF_DEPTH) (13); ROWS_PER_LINE=TILE_PER_LINE/TILE_PER_ROW (40).

Ports:
- clk_i  in  1  pixel clock (25 MHz)
- rst_i  in  1  synchronous reset, active-high
- pxl_cntr_i  in  PXL_CTR_WIDTH  horizontal pixel counter
- ln_cntr_i  in  LN_CTR_WIDTH  line counter
- fbuff_wr_en_i  in  1  external write strobe
- fbuff_wr_addr_i  in  FBUFF_ADDR_WIDTH  write row address
- fbuff_wr_data_i  in  FBUFF_DATA_WIDTH  write data; tile k at bits [k*PXL_WIDTH +: PXL_WIDTH]
- disp_pxl_o  out  PXL_WIDTH  pixel for current counters

Behaviour:
- Frame-buffer layout:
  - Row r holds tiles 4r..4r+3, left to right.
  - Tile line L occupies rows L*40..L*40+39.
  - Storage is synchronous single-port RAM. No reset of contents.
- Write priority:
  - Writes are accepted in any cycle and take priority over internal reads.
  - A read colliding with a write stalls one cycle.
- Internal read handshake:
  - rd_req pulse with address.
  - rd_rsp asserted exactly one cycle later, with registered data valid in that same cycle.
- Visible window: V_B_PORCH_MAX_LNS <= ln < V_B_PORCH_MAX_LNS+HEIGHT_LNS and H_B_PORCH_MAX_PX <= px < H_B_PORCH_MAX_PX+WIDTH_PX.
  - d = ln - V_B_PORCH_MAX_LNS
  - tile line L = d/TILE_WIDTH
  - tile id = (px - H_B_PORCH_MAX_PX)/TILE_WIDTH
- Pixel output:
  - Inside the window, disp_pxl_o = linebuf[L%2][tile id]. This is combinational from the counters, so it is valid in the same cycle.
  - Outside the window, disp_pxl_o = 0.
- Line buffers: two arrays of TILE_PER_LINE x PXL_WIDTH registers.
- Fill scheduling:
  - At ln==0, px==0: fill buffer 0 with tile line 0.
  - At px==0 of visible line d where d%TILE_WIDTH==0 and L+1<TILE_LINES: fill buffer (L+1)%2 with tile line L+1.
  - The buffer being displayed is never written.
- Fill FSM: IDLE -> REQ -> WAIT -> (REQ | DONE) -> IDLE.
  - REQ issues a read of row L*40+i.
  - WAIT captures 4 tiles into slots 4i..4i+3 on rd_rsp, then increments i.
  - After i=39, go to DONE. DONE pulses buff_fill_done[buf] for one cycle, then IDLE.
  - Fill completes in <=120 cycles unless stalled by writes, well inside the 3200-cycle slack.
  - A fill trigger arriving while not IDLE is ignored.
- Reset (synchronous):
  - FSM to IDLE, row index 0, fill_done 0, disp_pxl_o 0.
  - Line-buffer contents are cleared to 0.
  - Any fill in progress is abandoned; the next frame start refills.
- Wrap: after the last visible line no fill is issued; ln returning to 0 restarts at tile line 0.

Decomposition:
- Package vga_line_pkg: parameters and derived constants, pixel_t (logic [PXL_WIDTH-1:0]), fbuff_word_t, fill FSM state enum.
- One sub-module, fbuff_ram: RAM plus write port and one-cycle read request/response.
- Controller, line buffers and output mux live in the top.

Test Plan:
- Load all 4800 rows, then run counters from 0:
  - Tile line L, tile t holds {3{c}}. Even lines count c up from 0x0 and odd lines count down from 0xF, each wrapping modulo 16 along the line.
  - Check ln=35,px=144 -> 0x000; px=148 -> 0x111; px=783 -> 0xFFF; ln=39,px=144 -> 0xFFF; ln=514,px=783 -> 0x000.
- Every cycle outside the window (e.g. ln=10 or px=100) -> disp_pxl_o == 0.
- Every visible pixel of two consecutive frames matches the reference array; frame 2 is identical (wrap).
- Fill timing: after trigger at ln=35,px=0, the fill-done pulse for buffer 1 occurs <=121 cycles later; no write occurs to buffer 0 during tile line 0.
- Assert rst_i at ln=35,px=20 for 1 cycle, then restart counters at 0 -> disp_pxl_o 0 during reset; the next frame is fully correct.
- External write to row 0 during display (data 0x…ABC in tile 0) -> visible from the next frame at ln=35,px=144 = 0xABC; the concurrent fill still completes correctly.
